npc_mem_bridge: RTL and testbench

- Sits directly downstream of the single-cycle core's data-memory port (mem_ce/mem_we/mem_raddr/mem_waddr/mem_wdata/mem_rdata).
- Converts each single-cycle memory request into one valid/ready request plus one valid/ready response on a multi-cycle bus.
- Asserts hold_o so the core freezes its PC and register writeback until the access completes.
- Bounds every response wait with a timeout that reports an error.

---
 rtl/npc_bus_defs.sv | 20 ++
 rtl/npc_bus_timer.sv | 42 ++++
 rtl/npc_mem_bridge.sv | 131 +++++++++++++
 tb/tb_npc_mem_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_bus_defs.sv
// Shared definitions for the core-to-bus memory bridge: bus widths,
// FSM state encodings and the width of the response timeout counter.
package npc_bus_defs;

  // Core data / address bus widths.
  localparam int MemBus     = 64;
  localparam int MemAddrBus = 64;

  // Width of the WAIT-state timeout counter (TIMEOUT_CYC <= 65535).
  localparam int NPC_BR_CNT_W = 16;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    NPC_BR_IDLE = 2'd0,
    NPC_BR_REQ  = 2'd1,
    NPC_BR_WAIT = 2'd2,
    NPC_BR_DONE = 2'd3
  } npc_br_state_e;

endpackage

// File: rtl/npc_bus_timer.sv
// Clearable, enabled up-counter that flags when it reaches TIMEOUT_CYC-1.
// The bridge enables it in WAIT and clears it in DONE, so the flag rises
// on the TIMEOUT_CYC-th WAIT cycle.
module npc_bus_timer
  import npc_bus_defs::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [NPC_BR_CNT_W-1:0] TC_VAL = NPC_BR_CNT_W'(TIMEOUT_CYC - 1);

  logic [NPC_BR_CNT_W-1:0] cnt_q;
  logic [NPC_BR_CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/npc_mem_bridge.sv
// Turns each single-cycle data-memory access from the core into one
// valid/ready request and one valid/ready response on a multi-cycle bus,
// stalling the core with hold_o until the access completes.
//
// Handshake rule for both bus channels: a transfer happens on a rising
// clk edge where valid and ready are both 1; while valid is 1 and ready
// is 0 the sender keeps valid and every payload field unchanged.
module npc_mem_bridge
  import npc_bus_defs::*;
#(
  parameter int DATA_W      = MemBus,
  parameter int ADDR_W      = MemAddrBus,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  // core data-memory port
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              hold_o,
  output logic              err_o,
  // bus request channel
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic              bus_req_we_o,
  output logic [ADDR_W-1:0] bus_req_addr_o,
  output logic [DATA_W-1:0] bus_req_wdata_o,
  // bus response channel
  input  logic              bus_resp_valid_i,
  output logic              bus_resp_ready_o,
  input  logic [DATA_W-1:0] bus_resp_rdata_i,
  input  logic              bus_resp_err_i
);

  npc_br_state_e     state_q;
  logic              req_valid_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              resp_ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timeout;

  npc_bus_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == NPC_BR_DONE),
    .en_i (state_q == NPC_BR_WAIT),
    .tc_o (timeout)
  );

  // Access sequencer: latch the core request, run both bus handshakes,
  // then present the result to the core for one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NPC_BR_IDLE;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      resp_ready_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        NPC_BR_IDLE: begin
          err_q <= 1'b0;
          if (mem_ce_i) begin
            req_we_q    <= mem_we_i;
            req_addr_q  <= mem_we_i ? mem_waddr_i : mem_raddr_i;
            req_wdata_q <= mem_wdata_i;
            req_valid_q <= 1'b1;
            state_q     <= NPC_BR_REQ;
          end
        end
        NPC_BR_REQ: begin
          if (bus_req_ready_i) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            state_q      <= NPC_BR_WAIT;
          end
        end
        NPC_BR_WAIT: begin
          // A response in the timeout cycle still wins.
          if (bus_resp_valid_i) begin
            rdata_q      <= (req_we_q | bus_resp_err_i) ? '0 : bus_resp_rdata_i;
            err_q        <= bus_resp_err_i;
            resp_ready_q <= 1'b0;
            state_q      <= NPC_BR_DONE;
          end else if (timeout) begin
            rdata_q      <= '0;
            err_q        <= 1'b1;
            resp_ready_q <= 1'b0;
            state_q      <= NPC_BR_DONE;
          end
        end
        NPC_BR_DONE: begin
          // Result was visible for this one cycle; drop the error flag
          // so it never lingers into IDLE.
          err_q   <= 1'b0;
          state_q <= NPC_BR_IDLE;
        end
        default: begin
          state_q <= NPC_BR_IDLE;
        end
      endcase
    end
  end

  // Stall from the very first cycle of a request until DONE; forced low
  // while reset is held so the core sees a quiet port.
  assign hold_o = ~rst & (((state_q == NPC_BR_IDLE) & mem_ce_i) |
                          (state_q == NPC_BR_REQ) |
                          (state_q == NPC_BR_WAIT));

  assign mem_rdata_o      = rdata_q;
  assign err_o            = err_q;
  assign bus_req_valid_o  = req_valid_q;
  assign bus_req_we_o     = req_we_q;
  assign bus_req_addr_o   = req_addr_q;
  assign bus_req_wdata_o  = req_wdata_q;
  assign bus_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_npc_mem_bridge.sv
// Directed bench for npc_mem_bridge with TIMEOUT_CYC=8.
module tb_npc_mem_bridge;
  import npc_bus_defs::*;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mem_ce = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_raddr = '0;
  logic [AW-1:0] mem_waddr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata_o;
  logic          hold_o;
  logic          err_o;
  logic          bus_req_valid_o;
  logic          bus_req_ready = 1'b0;
  logic          bus_req_we_o;
  logic [AW-1:0] bus_req_addr_o;
  logic [DW-1:0] bus_req_wdata_o;
  logic          bus_resp_valid = 1'b0;
  logic          bus_resp_ready_o;
  logic [DW-1:0] bus_resp_rdata = '0;
  logic          bus_resp_err = 1'b0;

  npc_mem_bridge #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_ce_i        (mem_ce),
    .mem_we_i        (mem_we),
    .mem_raddr_i     (mem_raddr),
    .mem_waddr_i     (mem_waddr),
    .mem_wdata_i     (mem_wdata),
    .mem_rdata_o     (mem_rdata_o),
    .hold_o          (hold_o),
    .err_o           (err_o),
    .bus_req_valid_o (bus_req_valid_o),
    .bus_req_ready_i (bus_req_ready),
    .bus_req_we_o    (bus_req_we_o),
    .bus_req_addr_o  (bus_req_addr_o),
    .bus_req_wdata_o (bus_req_wdata_o),
    .bus_resp_valid_i(bus_resp_valid),
    .bus_resp_ready_o(bus_resp_ready_o),
    .bus_resp_rdata_i(bus_resp_rdata),
    .bus_resp_err_i  (bus_resp_err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_q[$];

  // Record every accepted bus request address.
  always @(posedge clk) begin
    if (!rst && bus_req_valid_o && bus_req_ready) obs_q.push_back(bus_req_addr_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_done(input string tag, input logic [63:0] rdata, input logic err);
    chk({tag, "_hold"}, 64'(hold_o), 64'd0);
    chk({tag, "_rdata"}, mem_rdata_o, rdata);
    chk({tag, "_err"}, 64'(err_o), 64'(err));
    chk({tag, "_rrdy"}, 64'(bus_resp_ready_o), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) next_cyc();
    #1;
    chk("rst_state", 64'(dut.state_q), 64'(NPC_BR_IDLE));
    chk("rst_hold", 64'(hold_o), 64'd0);
    chk("rst_rvalid", 64'(bus_req_valid_o), 64'd0);
    chk("rst_rrdy", 64'(bus_resp_ready_o), 64'd0);
    chk("rst_addr", bus_req_addr_o, 64'd0);
    chk("rst_rdata", mem_rdata_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    next_cyc();

    // T1: minimum-latency read; stray response during REQ is ignored
    mem_ce = 1'b1; mem_we = 1'b0; mem_raddr = 64'h8000_0010; bus_req_ready = 1'b1;
    exp_q.push_back(64'h8000_0010);
    #1; chk("t1_hold_c1", 64'(hold_o), 64'd1);
    next_cyc();
    mem_ce = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_rdata = 64'h5A5A;
    #1;
    chk("t1_hold_c2", 64'(hold_o), 64'd1);
    chk("t1_rvalid", 64'(bus_req_valid_o), 64'd1);
    chk("t1_addr", bus_req_addr_o, 64'h8000_0010);
    chk("t1_we", 64'(bus_req_we_o), 64'd0);
    chk("t1_rrdy_req", 64'(bus_resp_ready_o), 64'd0);
    next_cyc();
    bus_resp_valid = 1'b1; bus_resp_err = 1'b0; bus_resp_rdata = 64'hDEAD_BEEF_0000_1234;
    #1;
    chk("t1_hold_c3", 64'(hold_o), 64'd1);
    chk("t1_rvalid_w", 64'(bus_req_valid_o), 64'd0);
    chk("t1_rrdy_w", 64'(bus_resp_ready_o), 64'd1);
    next_cyc();
    bus_resp_valid = 1'b0;
    #1; chk_done("t1_done", 64'hDEAD_BEEF_0000_1234, 1'b0);
    next_cyc();
    #1; chk("t1_idle_hold", 64'(hold_o), 64'd0);
    chk("t1_nreq", 64'(obs_q.size()), 64'd1);

    // T2: write with ready low for 4 cycles; core inputs change mid-REQ
    mem_ce = 1'b1; mem_we = 1'b1; mem_waddr = 64'h8000_0100; mem_wdata = 64'h55;
    mem_raddr = 64'h9999; bus_req_ready = 1'b0;
    exp_q.push_back(64'h8000_0100);
    #1; chk("t2_hold_c1", 64'(hold_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      mem_ce = 1'b0; mem_we = 1'b0;
      mem_waddr = 64'hDEAD_0000 + 64'(i); mem_wdata = 64'(i);
      if (i == 4) bus_req_ready = 1'b1;
      #1;
      chk("t2_rvalid", 64'(bus_req_valid_o), 64'd1);
      chk("t2_addr", bus_req_addr_o, 64'h8000_0100);
      chk("t2_wdata", bus_req_wdata_o, 64'h55);
      chk("t2_we", 64'(bus_req_we_o), 64'd1);
      chk("t2_hold", 64'(hold_o), 64'd1);
    end
    next_cyc();
    bus_req_ready = 1'b0;
    #1;
    chk("t2_rvalid_w", 64'(bus_req_valid_o), 64'd0);
    chk("t2_rrdy_w", 64'(bus_resp_ready_o), 64'd1);
    next_cyc();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'hABCD;
    #1; chk("t2_hold_w2", 64'(hold_o), 64'd1);
    next_cyc();
    bus_resp_valid = 1'b0;
    #1; chk_done("t2_done", 64'd0, 1'b0);
    next_cyc();
    #1; chk("t2_idle_hold", 64'(hold_o), 64'd0);

    // T3: error response on a read
    mem_ce = 1'b1; mem_we = 1'b0; mem_raddr = 64'h8000_0020; bus_req_ready = 1'b1;
    exp_q.push_back(64'h8000_0020);
    next_cyc();
    mem_ce = 1'b0;
    next_cyc();
    bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_rdata = 64'h1234;
    next_cyc();
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    #1; chk_done("t3_done", 64'd0, 1'b1);
    next_cyc();
    #1;
    chk("t3_idle_err", 64'(err_o), 64'd0);
    chk("t3_idle_hold", 64'(hold_o), 64'd0);

    // T4a: timeout after exactly 8 WAIT cycles
    mem_ce = 1'b1; mem_raddr = 64'h8000_0030;
    exp_q.push_back(64'h8000_0030);
    next_cyc();
    mem_ce = 1'b0;
    next_cyc();
    for (int i = 1; i <= TO; i++) begin
      #1;
      chk("t4a_rrdy", 64'(bus_resp_ready_o), 64'd1);
      chk("t4a_hold", 64'(hold_o), 64'd1);
      next_cyc();
    end
    #1; chk_done("t4a_done", 64'd0, 1'b1);
    next_cyc();

    // T4b: response on the 8th WAIT cycle beats the timeout
    mem_ce = 1'b1; mem_raddr = 64'h8000_0038;
    exp_q.push_back(64'h8000_0038);
    next_cyc();
    mem_ce = 1'b0;
    next_cyc();
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) begin
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h0123_4567_89AB_CDEF;
      end
      #1;
      chk("t4b_rrdy", 64'(bus_resp_ready_o), 64'd1);
      next_cyc();
    end
    bus_resp_valid = 1'b0;
    #1; chk_done("t4b_done", 64'h0123_4567_89AB_CDEF, 1'b0);
    next_cyc();

    // T5: back-to-back with mem_ce held; ce toggling in REQ adds nothing
    mem_ce = 1'b1; mem_raddr = 64'h8000_0040; bus_req_ready = 1'b0;
    exp_q.push_back(64'h8000_0040);
    next_cyc();
    mem_raddr = 64'h8000_0048; mem_ce = 1'b0;
    #1; chk("t5_addr1", bus_req_addr_o, 64'h8000_0040);
    next_cyc();
    mem_ce = 1'b1; bus_req_ready = 1'b1;
    #1; chk("t5_addr1b", bus_req_addr_o, 64'h8000_0040);
    next_cyc();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'hAA;
    next_cyc();
    bus_resp_valid = 1'b0;
    #1; chk_done("t5_done1", 64'hAA, 1'b0);
    exp_q.push_back(64'h8000_0048);
    next_cyc();
    #1;
    chk("t5_idle_hold", 64'(hold_o), 64'd1);
    chk("t5_idle_rvalid", 64'(bus_req_valid_o), 64'd0);
    next_cyc();
    #1;
    chk("t5_addr2", bus_req_addr_o, 64'h8000_0048);
    chk("t5_rvalid2", 64'(bus_req_valid_o), 64'd1);
    next_cyc();
    mem_ce = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'hBB;
    next_cyc();
    bus_resp_valid = 1'b0;
    #1; chk_done("t5_done2", 64'hBB, 1'b0);
    next_cyc();

    // T6: asynchronous reset in WAIT, then a normal access
    mem_ce = 1'b1; mem_raddr = 64'h8000_0050;
    exp_q.push_back(64'h8000_0050);
    next_cyc();
    next_cyc();
    #1; chk("t6_rrdy_w", 64'(bus_resp_ready_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_state", 64'(dut.state_q), 64'(NPC_BR_IDLE));
    chk("t6_rrdy", 64'(bus_resp_ready_o), 64'd0);
    chk("t6_rvalid", 64'(bus_req_valid_o), 64'd0);
    chk("t6_hold", 64'(hold_o), 64'd0);
    chk("t6_addr", bus_req_addr_o, 64'd0);
    chk("t6_rdata", mem_rdata_o, 64'd0);
    next_cyc();
    rst = 1'b0; mem_raddr = 64'h8000_0060;
    exp_q.push_back(64'h8000_0060);
    #1; chk("t6_hold_new", 64'(hold_o), 64'd1);
    next_cyc();
    mem_ce = 1'b0;
    #1; chk("t6_addr_new", bus_req_addr_o, 64'h8000_0060);
    next_cyc();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h77;
    next_cyc();
    bus_resp_valid = 1'b0;
    #1; chk_done("t6_done", 64'h77, 1'b0);
    next_cyc();

    // Request log against expected
    chk("req_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("req_addr%0d", i), obs_q[i], exp_q[i]);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
